// File: rtl/imem_arbiter.sv
// Purpose: arbitrates one single-port SRAM between an instruction-fetch reader and a loader writer.
// Latency: grants and SRAM command are combinational in cycle N; fetch data returns in N+1.
// Backpressure: a stalled fetch response is parked in a hold register; no new fetch is granted while it is outstanding.
//
// Optional feature: define IMEM_ARB_RR_EN for round-robin arbitration on contested cycles;
// without it the loader always wins over fetch.
//
// Ports:
//   clk0, rst0                   single clock, synchronous active-high reset
//   f_req/f_addr/f_gnt           fetch request channel
//   f_rvalid/f_rdata/f_rready    fetch response channel (valid/ready)
//   f_flush                      drop any outstanding fetch response
//   l_req/l_addr/l_wdata/l_gnt   loader write channel (no response)
//   mem_csb0/mem_web0/mem_addr0/mem_din0/mem_dout0   SRAM port (active-low select/write)

module imem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk0,
    input  logic                  rst0,
    // fetch requester
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    input  logic                  f_rready,
    input  logic                  f_flush,
    // loader
    input  logic                  l_req,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [DATA_WIDTH-1:0] l_wdata,
    output logic                  l_gnt,
    // SRAM port
    output logic                  mem_csb0,
    output logic                  mem_web0,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    output logic [DATA_WIDTH-1:0] mem_din0,
    input  logic [DATA_WIDTH-1:0] mem_dout0
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no response outstanding
        ST_RESP = 2'd1,   // read data arriving on mem_dout0 this cycle
        ST_HOLD = 2'd2    // read data parked in hold_q
    } state_t;

    typedef struct packed {
        logic                  csb;
        logic                  web;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] din;
    } mem_cmd_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] hold_d;

    logic                  f_cand;
    logic                  l_cand;
    logic                  fetch_wins;
    mem_cmd_t              cmd;

    // ------------------------------------------------------------------
    // Candidate requests
    // ------------------------------------------------------------------
    // A fetch may only be granted if the current response (if any) leaves
    // this cycle, so at most one response is ever outstanding. Flush and
    // reset both kill fetch grants; reset also kills loader grants.
    always_comb begin
        f_cand = f_req && !rst0 && !f_flush &&
                 ((state_q == ST_IDLE) || f_rready);
        l_cand = l_req && !rst0;
    end

    // ------------------------------------------------------------------
    // Priority selection
    // ------------------------------------------------------------------
`ifdef IMEM_ARB_RR_EN
    // rr_fetch_pri_q=1 means fetch has priority on the next contested cycle.
    // Only contested cycles move it; the winner drops to lowest priority,
    // which with two requesters is simply a toggle.
    logic rr_fetch_pri_q;
    logic contested;

    always_comb begin
        contested  = f_cand && l_cand;
        fetch_wins = rr_fetch_pri_q;
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            rr_fetch_pri_q <= 1'b0;
        end else if (contested) begin
            rr_fetch_pri_q <= !rr_fetch_pri_q;
        end
    end
`else
    always_comb begin
        fetch_wins = 1'b0;
    end
`endif

    always_comb begin
        f_gnt = f_cand && (!l_cand || fetch_wins);
        l_gnt = l_cand && !f_gnt;
    end

    // ------------------------------------------------------------------
    // SRAM command: one command per cycle, idle fields forced to zero
    // ------------------------------------------------------------------
    always_comb begin
        cmd.csb  = 1'b1;
        cmd.web  = 1'b1;
        cmd.addr = '0;
        cmd.din  = '0;
        if (l_gnt) begin
            cmd.csb  = 1'b0;
            cmd.web  = 1'b0;
            cmd.addr = l_addr;
            cmd.din  = l_wdata;
        end else if (f_gnt) begin
            cmd.csb  = 1'b0;
            cmd.addr = f_addr;
        end
    end

    always_comb begin
        mem_csb0  = cmd.csb;
        mem_web0  = cmd.web;
        mem_addr0 = cmd.addr;
        mem_din0  = cmd.din;
    end

    // ------------------------------------------------------------------
    // Response FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Response FSM: next state and response outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        f_rvalid = 1'b0;
        f_rdata  = '0;

        // Response is invisible while reset or flush is asserted; f_rdata
        // is driven to zero whenever nothing valid is presented.
        if (!rst0 && !f_flush) begin
            case (state_q)
                ST_RESP: begin
                    f_rvalid = 1'b1;
                    f_rdata  = mem_dout0;
                end
                ST_HOLD: begin
                    f_rvalid = 1'b1;
                    f_rdata  = hold_q;
                end
                default: begin
                    f_rvalid = 1'b0;
                    f_rdata  = '0;
                end
            endcase
        end

        if (f_flush) begin
            // f_gnt is already suppressed, so nothing new is in flight.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (f_gnt) begin
                        state_d = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (f_rready) begin
                        state_d = f_gnt ? ST_RESP : ST_IDLE;
                    end else begin
                        // SRAM output is only valid this one cycle; park it.
                        state_d = ST_HOLD;
                        hold_d  = mem_dout0;
                    end
                end
                ST_HOLD: begin
                    if (f_rready) begin
                        state_d = f_gnt ? ST_RESP : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Purpose: self-checking bench for imem_arbiter with an SRAM model and a queue-based reference model.
// Latency: model expects read data one cycle after the fetch grant.
// Backpressure: model keeps at most one outstanding response and checks it is re-presented until accepted.

module tb_imem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk0;
    logic          rst0;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          f_rready;
    logic          f_flush;
    logic          l_req;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_gnt;
    logic          mem_csb0;
    logic          mem_web0;
    logic [AW-1:0] mem_addr0;
    logic [DW-1:0] mem_din0;
    logic [DW-1:0] mem_dout0;

    imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_rready  (f_rready),
        .f_flush   (f_flush),
        .l_req     (l_req),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .mem_csb0  (mem_csb0),
        .mem_web0  (mem_web0),
        .mem_addr0 (mem_addr0),
        .mem_din0  (mem_din0),
        .mem_dout0 (mem_dout0)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // SRAM model: read data only meaningful in the cycle after a read command;
    // any other cycle shows garbage so stale-data bugs are visible.
    logic [DW-1:0] sram [256];
    always @(posedge clk0) begin
        mem_dout0 <= $urandom;
        if (!mem_csb0) begin
            if (!mem_web0) sram[mem_addr0] <= mem_din0;
            else           mem_dout0 <= sram[mem_addr0];
        end
    end

    // Reference model state
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] pend_q [$];
    bit            rr_fetch_first;
    bit            prev_rst;
    int            checks;
    int            errors;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic step(input bit rst, input bit freq, input logic [AW-1:0] fa,
                        input bit rr, input bit fl, input bit lreq,
                        input logic [AW-1:0] la, input logic [DW-1:0] ld);
        bit            ev;
        bit            fc;
        bit            lc;
        bit            eg_f;
        bit            eg_l;
        bit            fwin;
        logic [DW-1:0] ed;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edin;

        rst0 = rst; f_req = freq; f_addr = fa; f_rready = rr; f_flush = fl;
        l_req = lreq; l_addr = la; l_wdata = ld;
        @(negedge clk0);

        ev = 1'b0; eg_f = 1'b0; eg_l = 1'b0; ed = '0;
        if (!rst) begin
            ev = (pend_q.size() != 0) && !fl;
            if (ev) ed = pend_q[0];
            fc = freq && !fl && ((pend_q.size() == 0) || rr);
            lc = lreq;
`ifdef IMEM_ARB_RR_EN
            fwin = rr_fetch_first;
`else
            fwin = 1'b0;
`endif
            eg_f = fc && (!lc || fwin);
            eg_l = lc && !eg_f;
        end
        eaddr = eg_l ? la : (eg_f ? fa : '0);
        edin  = eg_l ? ld : '0;

        chk("f_gnt",     {31'b0, f_gnt},    {31'b0, eg_f});
        chk("l_gnt",     {31'b0, l_gnt},    {31'b0, eg_l});
        chk("f_rvalid",  {31'b0, f_rvalid}, {31'b0, ev});
        if (ev || rst || prev_rst) chk("f_rdata", f_rdata, ed);
        chk("mem_csb0",  {31'b0, mem_csb0}, {31'b0, !(eg_f || eg_l)});
        chk("mem_web0",  {31'b0, mem_web0}, {31'b0, !eg_l});
        chk("mem_addr0", {24'b0, mem_addr0}, {24'b0, eaddr});
        chk("mem_din0",  mem_din0, edin);

        if (rst) begin
            pend_q.delete();
            rr_fetch_first = 1'b0;
        end else begin
            if (fl || (ev && rr)) pend_q.delete();
            if (eg_f) pend_q.push_back(shadow[fa]);
            if (eg_l) shadow[la] = ld;
            if (fc && lc) rr_fetch_first = !eg_f;
        end
        prev_rst = rst;

        @(posedge clk0);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rr_fetch_first = 1'b0;
        prev_rst = 1'b0;

        // Reset, then idle
        step(1, 0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 3, 1, 0, 1, 4, 32'h1234);   // requests ignored during reset
        step(0, 0, 0, 1, 0, 0, 0, 0);

        // Load then fetch a known instruction word
        step(0, 0, 0, 1, 0, 1, 8'd0, 32'h00518093);
        step(0, 1, 8'd0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("req050_word", shadow[0], 32'h00518093);

        // Fill addresses 1..15 with random words
        for (int a = 1; a < 16; a++) begin
            step(0, 0, 0, 1, 0, 1, AW'(a), $urandom);
        end

        // Back-to-back fetches 0,1 with consumer ready
        step(0, 1, 8'd0, 1, 0, 0, 0, 0);
        step(0, 1, 8'd1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);

        // Fetch 1, consumer stalls 3 cycles while fetch keeps requesting
        step(0, 1, 8'd1, 1, 0, 0, 0, 0);
        step(0, 1, 8'd2, 0, 0, 0, 0, 0);
        step(0, 1, 8'd2, 0, 0, 0, 0, 0);
        step(0, 1, 8'd2, 0, 0, 0, 0, 0);
        step(0, 1, 8'd2, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);

        // Contention for 4 cycles from a fresh reset
        step(1, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'd3, 1, 0, 1, 8'd20, 32'hA5A5_0000 + i);
        end
        step(0, 0, 0, 1, 0, 0, 0, 0);

        // Flush in the response cycle with a concurrent loader write
        step(0, 1, 8'd4, 1, 0, 0, 0, 0);
        step(0, 1, 8'd5, 0, 1, 1, 8'd21, 32'hDEAD_BEEF);
        step(0, 0, 0, 1, 0, 0, 0, 0);

        // Reset in the cycle after a fetch grant
        step(0, 1, 8'd6, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) != 0,
                 AW'($urandom_range(0, 15)),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 2) == 0,
                 AW'($urandom_range(0, 15)),
                 $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
